// File: rtl/hazard_tracker_if.sv
// Bypass/stall bundle between the D-stage decode and the hazard tracker.
// The slave side is the tracker: it reads the D-stage instruction and drives the
// stall request plus the per-stage producer/operand fields for the forwarding selector.
interface hazard_tracker_if #(
   parameter int TNEW_W = 2
);
   logic [31:0]       instr_D;
   logic              stall;
   logic [4:0]        A1_E;
   logic [4:0]        A2_E;
   logic [4:0]        A2_M;
   logic [4:0]        A3_E;
   logic [4:0]        A3_M;
   logic [4:0]        A3_W;
   logic              RegWr_E;
   logic              RegWr_M;
   logic              RegWr_W;
   logic [TNEW_W-1:0] Tnew_E;
   logic [TNEW_W-1:0] Tnew_M;

   modport master (
      output instr_D,
      input  stall, A1_E, A2_E, A2_M, A3_E, A3_M, A3_W,
      input  RegWr_E, RegWr_M, RegWr_W, Tnew_E, Tnew_M
   );

   modport slave (
      input  instr_D,
      output stall, A1_E, A2_E, A2_M, A3_E, A3_M, A3_W,
      output RegWr_E, RegWr_M, RegWr_W, Tnew_E, Tnew_M
   );
endinterface

// File: rtl/hazard_tracker.sv
// Producer-side hazard tracker for the 5-stage MIPS pipeline.
// Decodes the D-stage instruction into operand use times (Tuse) and a produced
// value (A3, Tnew), carries the producers down E/M/W, and raises stall whenever
// an operand is needed earlier than its producer in E or M can supply it.
module hazard_tracker #(
   parameter int TNEW_W    = 2,
   parameter int TUSE_NONE = 3
) (
   input  logic             clk,
   input  logic             reset,
   hazard_tracker_if.slave  bus
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;

   localparam logic [TNEW_W-1:0] T0     = TNEW_W'(0);
   localparam logic [TNEW_W-1:0] T1     = TNEW_W'(1);
   localparam logic [TNEW_W-1:0] T2     = TNEW_W'(2);
   localparam logic [TNEW_W-1:0] T_NONE = TNEW_W'(TUSE_NONE);

   // D-stage instruction fields
   logic [5:0] op_dec;
   logic [5:0] funct_dec;
   logic [4:0] rs_dec;
   logic [4:0] rt_dec;
   logic [4:0] rd_dec;

   assign op_dec    = bus.instr_D[31:26];
   assign rs_dec    = bus.instr_D[25:21];
   assign rt_dec    = bus.instr_D[20:16];
   assign rd_dec    = bus.instr_D[15:11];
   assign funct_dec = bus.instr_D[5:0];

   // Decode results
   logic [TNEW_W-1:0] tuse_rs_dec;
   logic [TNEW_W-1:0] tuse_rt_dec;
   logic [TNEW_W-1:0] tnew_dec;
   logic [4:0]        a3_dec;
   logic              writes_dec;
   logic              regwr_dec;

   // E/M/W pipeline state
   logic [4:0]        a1_e_q, a1_e_d;
   logic [4:0]        a2_e_q, a2_e_d;
   logic [4:0]        a3_e_q, a3_e_d;
   logic              regwr_e_q, regwr_e_d;
   logic [TNEW_W-1:0] tnew_e_q, tnew_e_d;
   logic [4:0]        a2_m_q, a2_m_d;
   logic [4:0]        a3_m_q, a3_m_d;
   logic              regwr_m_q, regwr_m_d;
   logic [TNEW_W-1:0] tnew_m_q, tnew_m_d;
   logic [4:0]        a3_w_q, a3_w_d;
   logic              regwr_w_q, regwr_w_d;

   logic              stall_any;

   // Decode instr_D into use/produce timing; unused operands keep T_NONE
   always_comb begin
      tuse_rs_dec = T_NONE;
      tuse_rt_dec = T_NONE;
      tnew_dec    = T0;
      a3_dec      = 5'd0;
      writes_dec  = 1'b0;
      case (op_dec)
         OP_SPECIAL: begin
            if (funct_dec == FN_ADDU || funct_dec == FN_SUBU) begin
               tuse_rs_dec = T1;
               tuse_rt_dec = T1;
               a3_dec      = rd_dec;
               tnew_dec    = T1;
               writes_dec  = 1'b1;
            end else if (funct_dec == FN_JR) begin
               tuse_rs_dec = T0;
            end
         end
         OP_ORI: begin
            tuse_rs_dec = T1;
            a3_dec      = rt_dec;
            tnew_dec    = T1;
            writes_dec  = 1'b1;
         end
         OP_LUI: begin
            a3_dec      = rt_dec;
            tnew_dec    = T1;
            writes_dec  = 1'b1;
         end
         OP_LW: begin
            tuse_rs_dec = T1;
            a3_dec      = rt_dec;
            tnew_dec    = T2;
            writes_dec  = 1'b1;
         end
         OP_SW: begin
            tuse_rs_dec = T1;
            tuse_rt_dec = T2;
         end
         OP_BEQ: begin
            tuse_rs_dec = T0;
            tuse_rt_dec = T0;
         end
         OP_JAL: begin
            // PC+8 is produced in E, so the link value is ready immediately
            a3_dec      = 5'd31;
            tnew_dec    = T0;
            writes_dec  = 1'b1;
         end
         OP_J:    ;
         default: ;
      endcase
      regwr_dec = writes_dec & (a3_dec != 5'd0);
   end

   // Per-operand hazard check: rs is operand 0, rt is operand 1
   logic [4:0]        src_idx  [2];
   logic [TNEW_W-1:0] src_tuse [2];
   logic [1:0]        stall_op;

   assign src_idx[0]  = rs_dec;
   assign src_idx[1]  = rt_dec;
   assign src_tuse[0] = tuse_rs_dec;
   assign src_tuse[1] = tuse_rt_dec;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         logic hit_e;
         logic hit_m;
         // A producer only blocks if its value arrives after the operand is needed
         assign hit_e = regwr_e_q && (a3_e_q == src_idx[gi]) && (src_tuse[gi] < tnew_e_q);
         assign hit_m = regwr_m_q && (a3_m_q == src_idx[gi]) && (src_tuse[gi] < tnew_m_q);
         assign stall_op[gi] = (src_idx[gi] != 5'd0) && (hit_e || hit_m);
      end
   endgenerate

   assign stall_any = |stall_op;

   // Next pipeline contents: bubble into E on stall, M and W always advance
   always_comb begin
      if (stall_any) begin
         a1_e_d    = 5'd0;
         a2_e_d    = 5'd0;
         a3_e_d    = 5'd0;
         regwr_e_d = 1'b0;
         tnew_e_d  = T0;
      end else begin
         a1_e_d    = rs_dec;
         a2_e_d    = rt_dec;
         a3_e_d    = a3_dec;
         regwr_e_d = regwr_dec;
         tnew_e_d  = tnew_dec;
      end
      a2_m_d    = a2_e_q;
      a3_m_d    = a3_e_q;
      regwr_m_d = regwr_e_q;
      // Saturating countdown so a ready value never wraps to "far away"
      tnew_m_d  = (tnew_e_q == T0) ? T0 : (tnew_e_q - T1);
      a3_w_d    = a3_m_q;
      regwr_w_d = regwr_m_q;
   end

   // Pipeline registers; reset empties every stage and wins over stall
   always_ff @(posedge clk) begin
      if (!reset) begin
         a1_e_q    <= 5'd0;
         a2_e_q    <= 5'd0;
         a3_e_q    <= 5'd0;
         regwr_e_q <= 1'b0;
         tnew_e_q  <= T0;
         a2_m_q    <= 5'd0;
         a3_m_q    <= 5'd0;
         regwr_m_q <= 1'b0;
         tnew_m_q  <= T0;
         a3_w_q    <= 5'd0;
         regwr_w_q <= 1'b0;
      end else begin
         a1_e_q    <= a1_e_d;
         a2_e_q    <= a2_e_d;
         a3_e_q    <= a3_e_d;
         regwr_e_q <= regwr_e_d;
         tnew_e_q  <= tnew_e_d;
         a2_m_q    <= a2_m_d;
         a3_m_q    <= a3_m_d;
         regwr_m_q <= regwr_m_d;
         tnew_m_q  <= tnew_m_d;
         a3_w_q    <= a3_w_d;
         regwr_w_q <= regwr_w_d;
      end
   end

   assign bus.stall   = stall_any;
   assign bus.A1_E    = a1_e_q;
   assign bus.A2_E    = a2_e_q;
   assign bus.A2_M    = a2_m_q;
   assign bus.A3_E    = a3_e_q;
   assign bus.A3_M    = a3_m_q;
   assign bus.A3_W    = a3_w_q;
   assign bus.RegWr_E = regwr_e_q;
   assign bus.RegWr_M = regwr_m_q;
   assign bus.RegWr_W = regwr_w_q;
   assign bus.Tnew_E  = tnew_e_q;
   assign bus.Tnew_M  = tnew_m_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed hazard scenarios plus random instruction
// streams, checked against a timestamp-based model of in-flight producers.
module tb_hazard_tracker;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_tracker_if #(.TNEW_W(2)) bus ();

   hazard_tracker #(.TNEW_W(2), .TUSE_NONE(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each stage holds the producer that occupies it and the absolute cycle at
   // which its result becomes available; Tnew is derived as ready - now.
   typedef struct {
      logic [4:0] rs, rt, dest;
      logic       wr;
      int         ready;
   } slot_t;

   typedef struct {
      logic [4:0] dest;
      logic       wr;
      int         tnew, use_rs, use_rt;
   } dec_t;

   slot_t se, sm, sw;
   int    cyc = 0;

   function automatic dec_t decode(input logic [31:0] i);
      dec_t d;
      logic [5:0] op, fn;
      op = i[31:26];
      fn = i[5:0];
      d.use_rs = 3; d.use_rt = 3; d.dest = 5'd0; d.tnew = 0;
      if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
         d.use_rs = 1; d.use_rt = 1; d.dest = i[15:11]; d.tnew = 1;
      end else if (op == 6'h00 && fn == 6'h08) d.use_rs = 0;
      else if (op == 6'h0d) begin d.use_rs = 1; d.dest = i[20:16]; d.tnew = 1; end
      else if (op == 6'h0f) begin d.dest = i[20:16]; d.tnew = 1; end
      else if (op == 6'h23) begin d.use_rs = 1; d.dest = i[20:16]; d.tnew = 2; end
      else if (op == 6'h2b) begin d.use_rs = 1; d.use_rt = 2; end
      else if (op == 6'h04) begin d.use_rs = 0; d.use_rt = 0; end
      else if (op == 6'h03) begin d.dest = 5'd31; d.tnew = 0; end
      d.wr = (d.dest != 5'd0);
      return d;
   endfunction

   function automatic bit needs_wait(input logic [4:0] r, input int use_t);
      if (r == 5'd0) return 1'b0;
      return (se.wr && se.dest == r && (se.ready - cyc) > use_t) ||
             (sm.wr && sm.dest == r && (sm.ready - cyc) > use_t);
   endfunction

   function automatic slot_t empty_slot();
      slot_t s;
      s.rs = 5'd0; s.rt = 5'd0; s.dest = 5'd0; s.wr = 1'b0; s.ready = cyc + 1;
      return s;
   endfunction

   // One clock: drive D inputs, check everything, advance model at the edge
   task automatic run_cycle(input logic rst_n, input logic [31:0] instr, input bit chk_en,
                            output bit exp_stall, output logic obs_stall);
      dec_t d;
      int   tm;
      @(negedge clk);
      reset       = rst_n;
      bus.instr_D = instr;
      #1;
      d         = decode(instr);
      exp_stall = needs_wait(instr[25:21], d.use_rs) || needs_wait(instr[20:16], d.use_rt);
      obs_stall = bus.stall;
      if (chk_en) begin
         tm = sm.ready - cyc;
         if (tm < 0) tm = 0;
         chk("stall",   {31'd0, bus.stall},   {31'd0, exp_stall});
         chk("A1_E",    {27'd0, bus.A1_E},    {27'd0, se.rs});
         chk("A2_E",    {27'd0, bus.A2_E},    {27'd0, se.rt});
         chk("A3_E",    {27'd0, bus.A3_E},    {27'd0, se.dest});
         chk("RegWr_E", {31'd0, bus.RegWr_E}, {31'd0, se.wr});
         chk("Tnew_E",  {30'd0, bus.Tnew_E},  se.ready - cyc);
         chk("A2_M",    {27'd0, bus.A2_M},    {27'd0, sm.rt});
         chk("A3_M",    {27'd0, bus.A3_M},    {27'd0, sm.dest});
         chk("RegWr_M", {31'd0, bus.RegWr_M}, {31'd0, sm.wr});
         chk("Tnew_M",  {30'd0, bus.Tnew_M},  tm);
         chk("A3_W",    {27'd0, bus.A3_W},    {27'd0, sw.dest});
         chk("RegWr_W", {31'd0, bus.RegWr_W}, {31'd0, sw.wr});
      end
      $display("cyc %0d rst_n %b instr %h stall %b A3 E/M/W %0d/%0d/%0d",
               cyc, rst_n, instr, bus.stall, bus.A3_E, bus.A3_M, bus.A3_W);
      @(posedge clk);
      if (!rst_n) begin
         se = empty_slot(); sm = empty_slot(); sw = empty_slot();
      end else begin
         sw = sm;
         sm = se;
         if (exp_stall) se = empty_slot();
         else begin
            se.rs = instr[25:21]; se.rt = instr[20:16];
            se.dest = d.dest; se.wr = d.wr; se.ready = cyc + 1 + d.tnew;
         end
      end
      cyc++;
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 4));
      b = 5'($urandom_range(0, 4));
      c = 5'($urandom_range(0, 4));
      case ($urandom_range(0, 11))
         0:  return enc_r(6'h21, a, b, c);
         1:  return enc_r(6'h23, a, b, c);
         2:  return enc_i(6'h0d, a, b, 16'($urandom));
         3:  return enc_i(6'h0f, a, b, 16'($urandom));
         4:  return enc_i(6'h23, a, b, 16'($urandom));
         5:  return enc_i(6'h2b, a, b, 16'($urandom));
         6:  return enc_i(6'h04, a, b, 16'($urandom));
         7:  return enc_r(6'h08, a, 5'd0, 5'd0);
         8:  return {6'h03, 26'($urandom)};
         9:  return {6'h02, 26'($urandom)};
         10: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   bit   es;
   logic os;

   task automatic drain();
      for (int k = 0; k < 3; k++) run_cycle(1'b1, 32'd0, 1'b1, es, os);
   endtask

   // Producer a then consumer b; b must be held for exactly n_stall stall cycles
   task automatic pair(input string name, input logic [31:0] a, input logic [31:0] b,
                       input int n_stall);
      run_cycle(1'b1, a, 1'b1, es, os);
      chk({name, "_first"}, {31'd0, os}, 32'd0);
      for (int k = 0; k <= n_stall; k++) begin
         run_cycle(1'b1, b, 1'b1, es, os);
         chk($sformatf("%s_c%0d", name, k), {31'd0, os}, (k < n_stall) ? 32'd1 : 32'd0);
      end
      drain();
   endtask

   logic [31:0] cur;

   initial begin
      reset       = 1'b0;
      bus.instr_D = 32'd0;
      se = empty_slot(); sm = empty_slot(); sw = empty_slot();
      run_cycle(1'b0, 32'd0, 1'b0, es, os);
      run_cycle(1'b0, 32'd0, 1'b1, es, os);
      drain();

      pair("load_use",  enc_i(6'h23, 5'd0, 5'd1, 16'd0), enc_r(6'h21, 5'd1, 5'd1, 5'd2), 1);
      pair("alu_br",    enc_i(6'h0d, 5'd0, 5'd1, 16'd5), enc_i(6'h04, 5'd1, 5'd0, 16'd0), 1);
      pair("load_br",   enc_i(6'h23, 5'd0, 5'd3, 16'd0), enc_i(6'h04, 5'd3, 5'd3, 16'd0), 2);
      pair("jal_jr",    {6'h03, 26'h10}, enc_r(6'h08, 5'd31, 5'd0, 5'd0), 0);
      pair("lw_sw",     enc_i(6'h23, 5'd0, 5'd4, 16'd0), enc_i(6'h2b, 5'd0, 5'd4, 16'd0), 0);
      pair("zero_dst",  enc_r(6'h21, 5'd1, 5'd1, 5'd0), enc_i(6'h04, 5'd0, 5'd0, 16'd0), 0);
      pair("lone_lw",   enc_i(6'h23, 5'd0, 5'd5, 16'd0), 32'd0, 0);
      pair("lone_jal",  {6'h03, 26'h20}, 32'd0, 0);

      // Reset in the middle of a load-use stall
      run_cycle(1'b1, enc_i(6'h23, 5'd0, 5'd1, 16'd0), 1'b1, es, os);
      run_cycle(1'b1, enc_r(6'h21, 5'd1, 5'd1, 5'd2), 1'b1, es, os);
      chk("rst_mid_stall", {31'd0, os}, 32'd1);
      run_cycle(1'b0, enc_r(6'h21, 5'd1, 5'd1, 5'd2), 1'b1, es, os);
      run_cycle(1'b1, 32'd0, 1'b1, es, os);
      chk("rst_after", {31'd0, os}, 32'd0);
      run_cycle(1'b1, 32'd0, 1'b1, es, os);

      // Random streams; the D register is frozen while stall is asserted
      cur = rand_instr();
      for (int n = 0; n < 400; n++) begin
         run_cycle(($urandom_range(0, 39) != 0), cur, 1'b1, es, os);
         if (!es) cur = rand_instr();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the register bypass network in the 5-stage MIPS pipeline.
- Decodes instr_D into register-use times (Tuse) and destination/produce times (A3, Tnew).
- Carries A3/RegWr/Tnew and operand indices down the E/M/W pipeline registers.
- Drives the stall/bubble decision and feeds the forwarding selector with A3_E/M/W, RegWr_E/M/W, Tnew_E/M, A1_E, A2_E and A2_M.

Parameters:
- TNEW_W, 2, width of Tnew fields.
- TUSE_NONE, 3, Tuse code for an operand the instruction does not read.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- instr_D  input  32  instruction in D stage
- stall  output  1  freeze PC and D register, insert bubble into E
- A1_E  output  5  rs index of instruction in E
- A2_E  output  5  rt index of instruction in E
- A2_M  output  5  rt index of instruction in M
- A3_E  output  5  destination register in E
- A3_M  output  5  destination register in M
- A3_W  output  5  destination register in W
- RegWr_E  output  1  E instruction writes GRF
- RegWr_M  output  1  M instruction writes GRF
- RegWr_W  output  1  W instruction writes GRF
- Tnew_E  output  2  cycles until E result is available
- Tnew_M  output  2  cycles until M result is available

Behaviour:
- Decode (combinational, D stage), rs = [25:21], rt = [20:16], rd = [15:11]:
  - addu (op 0, funct 0x21) and subu (funct 0x23): Tuse_rs=1, Tuse_rt=1, A3=rd, Tnew=1.
  - ori (0x0d): Tuse_rs=1, A3=rt, Tnew=1.
  - lui (0x0f): A3=rt, Tnew=1.
  - lw (0x23): Tuse_rs=1, A3=rt, Tnew=2.
  - sw (0x2b): Tuse_rs=1, Tuse_rt=2, no write.
  - beq (0x04): Tuse_rs=0, Tuse_rt=0, no write.
  - jr (op 0, funct 0x08): Tuse_rs=0, no write.
  - jal (0x03): A3=31, Tnew=0 (PC+8 is available in E).
  - j (0x02), nop, and any unlisted encoding: no use, no write.
  - Unused operands get Tuse = TUSE_NONE.
  - RegWr_D = 1 only for writing instructions with A3 != 0. A write to $0 is treated as no write.
- Stall (combinational):
  - stall_rs = (rs != 0) & [ (rs == A3_E & RegWr_E & Tuse_rs < Tnew_E) | (rs == A3_M & RegWr_M & Tuse_rs < Tnew_M) ].
  - stall_rt is the same condition using rt and Tuse_rt.
  - stall = stall_rs | stall_rt.
  - TUSE_NONE (3) never stalls because Tnew never exceeds 2.
  - W stage never causes a stall.
- Pipeline registers, updated on each rising clk:
  - reset == 0: every E/M/W field is cleared to 0 (A*, RegWr*, Tnew*). With all stages empty, stall then evaluates to 0.
  - stall == 1: E loads a bubble (all fields 0). M <= E and W <= M still advance.
  - stall == 0: E loads the D decode (A1_E=rs, A2_E=rt, A3_E, RegWr_E, Tnew_E).
  - M <= E with Tnew_M = (Tnew_E == 0) ? 0 : Tnew_E - 1 (saturating decrement, no wrap). A2_M <= A2_E.
  - W <= M for A3 and RegWr. W Tnew is implicitly 0 and is not stored.
- Reset has priority over stall. Reset in mid-operation discards all in-flight producers.
- Simultaneous rs and rt hazards give a single stall; the stall lasts until both clear.
- There is no latency beyond one stage per cycle. Outputs are register-driven, except stall.
- The decoder is purely a function of instr_D. The block does not latch instr_D; the D register is owned outside.

Test Plan:
- Load-use: lw $1,0($0) then addu $2,$1,$1 → stall=1 for exactly 1 cycle, E bubble (A3_E=0, RegWr_E=0). Next cycle Tnew_M=1, stall=0. Then A3_W=1, RegWr_W=1.
- ALU-to-branch: ori $1,$0,5 then beq $1,$0 → 1 stall cycle (Tnew_E=1 > Tuse 0). Released when Tnew_M=0.
- Load-to-branch: lw $3 then beq $3,$3 → 2 consecutive stall cycles (Tnew_E=2, then Tnew_M=1). Released on the third cycle.
- No-stall cases, stall must stay 0:
  - jal then jr $31: A3_E=31, Tnew_E=0.
  - lw $4 then sw $4,0($0): Tuse_rt=2 equals Tnew_E=2.
  - addu $0,$1,$1 then beq $0,$0: RegWr_E=0.
- Tnew decrement: a lone lw $5 flows through E/M/W → Tnew_E=2, Tnew_M=1, then A3_W=5. A lone jal → Tnew_E=0, then Tnew_M=0 with no underflow.
- Reset mid-op: lw $1 in E and addu $2,$1,$1 in D (stall=1), then drive reset=0 for one cycle → all outputs 0 and stall=0 after the edge. Released reset with a nop in D → outputs stay 0.
